fa_response_checker: RTL and testbench

Self-checking response monitor for the full-adder error-analysis flow. It accepts a stream of applied full-adder vectors together with the observed outputs (a, b, c_in, sum, carry_out). For each vector it computes the golden result and counts mismatches. It captures the first failing vector, then reports pass/fail once a programmed number of vectors has been consumed. It sits on the response side of the stimulus path: stimulus generators and DUT wrappers feed it, and the error-analysis logic reads its result registers.

---
 rtl/fa_response_checker.sv | 103 ++++++++++
 tb/tb_fa_response_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fa_response_checker.sv
// Response monitor for full-adder vector streams: recomputes the golden sum/carry,
// counts mismatches (saturating), captures the first failing vector and reports pass/fail.
module fa_response_checker #(
    parameter int VEC_CNT_W = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_CNT_W-1:0] num_vecs,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_a,
    input  logic                 in_b,
    input  logic                 in_c_in,
    input  logic                 in_sum,
    input  logic                 in_carry_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [VEC_CNT_W-1:0] vec_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ERR_CNT_W-1:0] sum_err_count,
    output logic [ERR_CNT_W-1:0] carry_err_count,
    output logic                 first_err_valid,
    output logic [VEC_CNT_W-1:0] first_err_idx,
    output logic [4:0]           first_err_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [VEC_CNT_W-1:0] num_lat;
    logic                 arm, xfer, last;
    logic                 exp_sum, exp_co, sum_mis, co_mis, any_mis;

    assign arm     = start && (state != RUN);
    assign xfer    = in_valid && (state == RUN);
    assign last    = (vec_count == num_lat - VEC_CNT_W'(1));

    assign exp_sum = in_a ^ in_b ^ in_c_in;
    assign exp_co  = (in_a & in_b) | (in_a & in_c_in) | (in_b & in_c_in);
    assign sum_mis = in_sum != exp_sum;
    assign co_mis  = in_carry_out != exp_co;
    assign any_mis = sum_mis || co_mis;

    // Status outputs are pure decodes of registered state, so no input-to-output path exists.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign pass     = (state == DONE) && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = (num_vecs == '0) ? DONE : RUN;
            RUN:        if (xfer && last) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat         <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            sum_err_count   <= '0;
            carry_err_count <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_vec   <= '0;
        end else if (arm) begin
            num_lat         <= num_vecs;
            vec_count       <= '0;
            err_count       <= '0;
            sum_err_count   <= '0;
            carry_err_count <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_vec   <= '0;
        end else if (xfer) begin
            vec_count <= vec_count + VEC_CNT_W'(1);
            // Error counters stick at all-ones rather than wrapping.
            if (sum_mis && sum_err_count != '1)
                sum_err_count <= sum_err_count + ERR_CNT_W'(1);
            if (co_mis && carry_err_count != '1)
                carry_err_count <= carry_err_count + ERR_CNT_W'(1);
            if (any_mis && err_count != '1)
                err_count <= err_count + ERR_CNT_W'(1);
            if (any_mis && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= vec_count;
                first_err_vec   <= {in_a, in_b, in_c_in, in_sum, in_carry_out};
            end
        end
    end

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: two instances (8-bit and 2-bit error counters)
// share stimulus and are compared every cycle against an integer-level behavioural model.
module tb_fa_response_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_vecs = '0;
    logic        in_valid = 1'b0;
    logic        in_a = 0, in_b = 0, in_c_in = 0, in_sum = 0, in_carry_out = 0;

    logic        rdy8, busy8, done8, pass8, fev8;
    logic [15:0] vc8, fidx8;
    logic [7:0]  ec8, sec8, cec8;
    logic [4:0]  fvec8;

    logic        rdy2, busy2, done2, pass2, fev2;
    logic [15:0] vc2, fidx2;
    logic [1:0]  ec2, sec2, cec2;
    logic [4:0]  fvec2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fa_response_checker #(.VEC_CNT_W(16), .ERR_CNT_W(8)) d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
        .in_valid(in_valid), .in_ready(rdy8), .in_a(in_a), .in_b(in_b),
        .in_c_in(in_c_in), .in_sum(in_sum), .in_carry_out(in_carry_out),
        .busy(busy8), .done(done8), .pass(pass8), .vec_count(vc8),
        .err_count(ec8), .sum_err_count(sec8), .carry_err_count(cec8),
        .first_err_valid(fev8), .first_err_idx(fidx8), .first_err_vec(fvec8));

    fa_response_checker #(.VEC_CNT_W(16), .ERR_CNT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs),
        .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
        .in_c_in(in_c_in), .in_sum(in_sum), .in_carry_out(in_carry_out),
        .busy(busy2), .done(done2), .pass(pass2), .vec_count(vc2),
        .err_count(ec2), .sum_err_count(sec2), .carry_err_count(cec2),
        .first_err_valid(fev2), .first_err_idx(fidx2), .first_err_vec(fvec2));

    // Behavioural model: mode 0 idle, 1 running, 2 finished; counts are unbounded ints.
    int m_mode = 0, m_n = 0, m_cnt = 0, m_err = 0, m_serr = 0, m_cerr = 0;
    int m_fv = 0, m_fidx = 0, m_fvec = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_n <= 0; m_cnt <= 0; m_err <= 0; m_serr <= 0; m_cerr <= 0;
            m_fv <= 0; m_fidx <= 0; m_fvec <= 0;
        end else if (m_mode != 1 && start) begin
            m_n <= int'(num_vecs); m_cnt <= 0; m_err <= 0; m_serr <= 0; m_cerr <= 0;
            m_fv <= 0; m_fidx <= 0; m_fvec <= 0;
            m_mode <= (num_vecs == 0) ? 2 : 1;
        end else if (m_mode == 1 && in_valid) begin
            int total, smis, cmis;
            total = int'(in_a) + int'(in_b) + int'(in_c_in);
            smis  = (int'(in_sum) != total % 2) ? 1 : 0;
            cmis  = (int'(in_carry_out) != total / 2) ? 1 : 0;
            m_serr <= m_serr + smis;
            m_cerr <= m_cerr + cmis;
            m_err  <= m_err + ((smis + cmis) > 0 ? 1 : 0);
            if ((smis + cmis) > 0 && m_fv == 0) begin
                m_fv   <= 1;
                m_fidx <= m_cnt;
                m_fvec <= int'({in_a, in_b, in_c_in, in_sum, in_carry_out});
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == m_n) m_mode <= 2;
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ep;
        ep = (m_mode == 2 && m_err == 0) ? 1 : 0;
        chk("ready8", 32'(rdy8), 32'(m_mode == 1));
        chk("busy8",  32'(busy8), 32'(m_mode == 1));
        chk("done8",  32'(done8), 32'(m_mode == 2));
        chk("pass8",  32'(pass8), ep);
        chk("vec8",   32'(vc8), m_cnt);
        chk("err8",   32'(ec8),  sat(m_err, 8));
        chk("serr8",  32'(sec8), sat(m_serr, 8));
        chk("cerr8",  32'(cec8), sat(m_cerr, 8));
        chk("fev8",   32'(fev8), m_fv);
        chk("fidx8",  32'(fidx8), m_fidx);
        chk("fvec8",  32'(fvec8), m_fvec);
        chk("ready2", 32'(rdy2), 32'(m_mode == 1));
        chk("done2",  32'(done2), 32'(m_mode == 2));
        chk("pass2",  32'(pass2), ep);
        chk("vec2",   32'(vc2), m_cnt);
        chk("err2",   32'(ec2),  sat(m_err, 2));
        chk("serr2",  32'(sec2), sat(m_serr, 2));
        chk("cerr2",  32'(cec2), sat(m_cerr, 2));
        chk("fidx2",  32'(fidx2), m_fidx);
        chk("fvec2",  32'(fvec2), m_fvec);
    end

    task automatic pulse_start(input logic [15:0] n);
        @(posedge clk); #1; start = 1'b1; num_vecs = n;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic send(input logic a, b, c, s, co);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_c_in = c; in_sum = s; in_carry_out = co;
    endtask

    task automatic idle();
        @(posedge clk); #1; in_valid = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_vec",  32'(vc8), 0);

        // Clean 4-vector run
        pulse_start(16'd4);
        send(0,0,0,0,0); send(1,0,0,1,0); send(0,1,0,1,0); send(1,1,0,0,1);
        idle();
        chk("t1_done", 32'(done8), 1);
        chk("t1_pass", 32'(pass8), 1);
        chk("t1_vec",  32'(vc8), 4);
        chk("t1_fev",  32'(fev8), 0);

        // Third vector has a wrong sum
        pulse_start(16'd4);
        send(0,0,0,0,0); send(1,0,0,1,0); send(0,1,0,0,0); send(1,1,0,0,1);
        idle();
        chk("t2_err",  32'(ec8), 1);
        chk("t2_serr", 32'(sec8), 1);
        chk("t2_cerr", 32'(cec8), 0);
        chk("t2_fidx", 32'(fidx8), 2);
        chk("t2_fvec", 32'(fvec8), 32'h08);
        chk("t2_pass", 32'(pass8), 0);

        // Six vectors wrong on both outputs: 2-bit counters saturate at 3
        pulse_start(16'd6);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send(v[2], v[1], v[0], ~(v[2]^v[1]^v[0]),
                 ~((v[2]&v[1])|(v[2]&v[0])|(v[1]&v[0])));
        end
        idle();
        chk("t3_err2",  32'(ec2), 3);
        chk("t3_serr2", 32'(sec2), 3);
        chk("t3_cerr2", 32'(cec2), 3);
        chk("t3_err8",  32'(ec8), 6);
        chk("t3_fidx",  32'(fidx8), 0);

        // Zero-length run, then re-arm from DONE with one vector
        pulse_start(16'd0);
        chk("t4_done",  32'(done8), 1);
        chk("t4_pass",  32'(pass8), 1);
        chk("t4_ready", 32'(rdy8), 0);
        pulse_start(16'd1);
        chk("t4_busy",  32'(busy8), 1);
        chk("t4_clr",   32'(ec8), 0);
        send(1,1,1,1,1);
        idle();
        chk("t4_done2", 32'(done8), 1);
        chk("t4_vec2",  32'(vc8), 1);

        // Gaps, mid-run start and num_vecs change
        pulse_start(16'd3);
        send(1,0,1,0,1);
        idle();
        @(posedge clk); #1;
        start = 1'b1; num_vecs = 16'd7;
        in_valid = 1'b1; in_a = 0; in_b = 0; in_c_in = 1; in_sum = 1; in_carry_out = 0;
        @(posedge clk); #1; start = 1'b0; in_valid = 1'b0;
        send(1,1,0,0,1);
        send(0,1,1,0,1);
        idle();
        chk("t5_vec",  32'(vc8), 3);
        chk("t5_done", 32'(done8), 1);
        chk("t5_pass", 32'(pass8), 1);

        // Asynchronous reset mid-run, then in_valid without start
        pulse_start(16'd4);
        send(0,0,0,0,0); send(1,0,0,1,0);
        @(posedge clk); #1; in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy8), 0);
        chk("t6_vec",  32'(vc8), 0);
        chk("t6_rdy",  32'(rdy8), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        send(0,0,0,1,1); send(1,1,1,1,1);
        idle();
        chk("t6_nocnt", 32'(vc8), 0);
        chk("t6_idle",  32'(busy8), 0);
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
